// File: rtl/scff_bist_ctrl.sv
// Scan-chain self-test controller: flushes the fabric chain, injects a single
// '1', measures its transit time to the tail and checks the tail goes quiet.
module scff_bist_ctrl #(
  parameter int unsigned MAX_CHAIN_LEN = 1024,
  parameter int unsigned CNT_W         = 12
) (
  input  logic             op_clk,
  input  logic             resetb,
  input  logic             start,
  input  logic [CNT_W-1:0] expected_len,
  input  logic             sc_tail,
  output logic             sc_head,
  output logic             test_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] measured_len,
  output logic             err_stuck,
  output logic             err_timeout,
  output logic             err_multi
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFlush  = 3'd1;
  localparam logic [2:0] StInject = 3'd2;
  localparam logic [2:0] StCount  = 3'd3;
  localparam logic [2:0] StTrail  = 3'd4;

  localparam logic [CNT_W-1:0] FlushLast = CNT_W'(MAX_CHAIN_LEN);
  localparam logic [CNT_W-1:0] CountLast = CNT_W'(2 * MAX_CHAIN_LEN - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic             pass_q, pass_d;
  logic             stuck_q, stuck_d;
  logic             tmo_q, tmo_d;
  logic             multi_q, multi_d;
  logic             done_q, done_d;
  logic             head_q, head_d;
  logic             ten_q, ten_d;
  logic             busy_q, busy_d;
  logic             multi_now;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    meas_d    = meas_q;
    pass_d    = pass_q;
    stuck_d   = stuck_q;
    tmo_d     = tmo_q;
    multi_d   = multi_q;
    done_d    = 1'b0;
    multi_now = multi_q | sc_tail;
    case (state_q)
      StIdle: begin
        if (start) begin
          exp_d   = expected_len;
          pass_d  = 1'b0;
          meas_d  = '0;
          stuck_d = 1'b0;
          tmo_d   = 1'b0;
          multi_d = 1'b0;
          cnt_d   = '0;
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (cnt_q == FlushLast) begin
          if (sc_tail) begin
            stuck_d = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d   = '0;
            state_d = StInject;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StInject: begin
        cnt_d   = '0;
        state_d = StCount;
      end
      StCount: begin
        // A pulse on the last allowed cycle wins over the timeout.
        if (sc_tail) begin
          meas_d  = cnt_q + 1'b1;
          cnt_d   = '0;
          state_d = StTrail;
        end else if (cnt_q == CountLast) begin
          tmo_d   = 1'b1;
          meas_d  = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTrail: begin
        multi_d = multi_now;
        if (cnt_q == CNT_W'(1)) begin
          pass_d  = !multi_now && (meas_q == exp_q);
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    head_d = (state_d == StInject);
    ten_d  = (state_d != StIdle);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge op_clk) begin
    if (!resetb) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      exp_q   <= '0;
      meas_q  <= '0;
      pass_q  <= 1'b0;
      stuck_q <= 1'b0;
      tmo_q   <= 1'b0;
      multi_q <= 1'b0;
      done_q  <= 1'b0;
      head_q  <= 1'b0;
      ten_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      meas_q  <= meas_d;
      pass_q  <= pass_d;
      stuck_q <= stuck_d;
      tmo_q   <= tmo_d;
      multi_q <= multi_d;
      done_q  <= done_d;
      head_q  <= head_d;
      ten_q   <= ten_d;
      busy_q  <= busy_d;
    end
  end

  assign sc_head      = head_q;
  assign test_en      = ten_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign measured_len = meas_q;
  assign err_stuck    = stuck_q;
  assign err_timeout  = tmo_q;
  assign err_multi    = multi_q;

endmodule

// File: tb/tb_scff_bist_ctrl.sv
// Bench for scff_bist_ctrl: a behavioural scan chain (randomly preloaded)
// sits between sc_head and sc_tail; results are checked against timing rules.
module tb_scff_bist_ctrl;
  localparam int MaxLen = 1024;
  localparam int CntW   = 12;

  logic            op_clk = 1'b0;
  logic            resetb = 1'b0;
  logic            start = 1'b0;
  logic [CntW-1:0] expected_len = '0;
  logic            sc_tail;
  logic            sc_head, test_en, busy, done, pass;
  logic [CntW-1:0] measured_len;
  logic            err_stuck, err_timeout, err_multi;

  int total = 0;
  int bad = 0;

  // 0: plain chain, 1: tail tied 0, 2: tail tied 1, 3: chain with an echo 2 FFs later
  int          mode = 0;
  int          tail_idx = 8;
  logic [1025:0] chain;
  logic        scramble = 1'b0;

  scff_bist_ctrl #(.MAX_CHAIN_LEN(MaxLen), .CNT_W(CntW)) dut (
    .op_clk(op_clk), .resetb(resetb), .start(start), .expected_len(expected_len),
    .sc_tail(sc_tail), .sc_head(sc_head), .test_en(test_en), .busy(busy), .done(done),
    .pass(pass), .measured_len(measured_len), .err_stuck(err_stuck),
    .err_timeout(err_timeout), .err_multi(err_multi)
  );

  always #5 op_clk = ~op_clk;

  always @(posedge op_clk) begin
    if (scramble) begin
      for (int i = 0; i < 1026; i++) chain[i] <= 1'($urandom_range(0, 1));
    end else if (test_en) begin
      chain <= {chain[1024:0], sc_head};
    end
  end

  always_comb begin
    case (mode)
      1:       sc_tail = 1'b0;
      2:       sc_tail = 1'b1;
      3:       sc_tail = chain[tail_idx-1] | chain[tail_idx+1];
      default: sc_tail = chain[tail_idx-1];
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic randomize_chain();
    @(negedge op_clk);
    scramble = 1'b1;
    @(negedge op_clk);
    scramble = 1'b0;
  endtask

  // Launches one test; returns the cycle of done (0 if never), sc_head stats and busy sanity.
  task automatic run_op(input logic [CntW-1:0] exp_len, output int done_cyc,
                        output int head_cnt, output int head_first, output int busy_bad);
    int cyc;
    done_cyc = 0; head_cnt = 0; head_first = 0; busy_bad = 0;
    randomize_chain();
    @(negedge op_clk);
    expected_len = exp_len;
    start = 1'b1;
    @(negedge op_clk);
    start = 1'b0;
    expected_len = ~exp_len;
    cyc = 1;
    while (cyc <= 4000) begin
      if (sc_head) begin
        if (head_cnt == 0) head_first = cyc;
        head_cnt++;
      end
      if (done) begin
        done_cyc = cyc;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      if (cyc == 10) start = 1'b1;
      if (cyc == 11) start = 1'b0;
      @(negedge op_clk);
      cyc++;
    end
  endtask

  task automatic good_chain(input string tag, input int n, input int exp_len);
    int dc, hc, hf, bb;
    mode = 0;
    tail_idx = n;
    run_op(CntW'(exp_len), dc, hc, hf, bb);
    check({tag, "_done_cycle"}, dc, MaxLen + n + 5);
    check({tag, "_head_cycles"}, hc, 1);
    check({tag, "_head_first"}, hf, MaxLen + 2);
    check({tag, "_busy"}, bb, 0);
    check({tag, "_meas"}, 32'(measured_len), n);
    check({tag, "_pass"}, 32'(pass), (n == exp_len) ? 1 : 0);
    check({tag, "_errs"}, {err_stuck, err_timeout, err_multi}, 0);
    @(negedge op_clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int dc, hc, hf, bb, n, e;
    mode = 2;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge op_clk);
      check("reset_outputs", {sc_head, test_en, busy, done, pass, measured_len,
                              err_stuck, err_timeout, err_multi}, 0);
    end
    start = 1'b0;
    mode = 0;
    resetb = 1'b1;
    @(negedge op_clk);
    check("post_reset_idle", {busy, done, test_en}, 0);

    good_chain("n1024", 1024, 1024);
    good_chain("n1000", 1000, 1024);

    mode = 1;
    run_op(CntW'(5), dc, hc, hf, bb);
    check("tmo_done_cycle", dc, MaxLen + 2 + 2 * MaxLen + 1);
    check("tmo_flag", {err_stuck, err_timeout, err_multi}, 3'b010);
    check("tmo_meas", 32'(measured_len), 0);
    check("tmo_pass", 32'(pass), 0);

    mode = 2;
    run_op(CntW'(5), dc, hc, hf, bb);
    check("stuck_done_cycle", dc, MaxLen + 2);
    check("stuck_flag", {err_stuck, err_timeout, err_multi}, 3'b100);
    check("stuck_head", hc, 0);
    check("stuck_pass", 32'(pass), 0);

    mode = 3;
    tail_idx = 8;
    run_op(CntW'(8), dc, hc, hf, bb);
    check("echo_done_cycle", dc, MaxLen + 8 + 5);
    check("echo_meas", 32'(measured_len), 8);
    check("echo_flag", {err_stuck, err_timeout, err_multi}, 3'b001);
    check("echo_pass", 32'(pass), 0);

    // Reset taken mid-COUNT aborts without a done pulse.
    mode = 0;
    tail_idx = 8;
    randomize_chain();
    @(negedge op_clk);
    expected_len = CntW'(8);
    start = 1'b1;
    @(negedge op_clk);
    start = 1'b0;
    repeat (MaxLen + 4) @(negedge op_clk);
    check("mid_busy", 32'(busy), 1);
    resetb = 1'b0;
    @(negedge op_clk);
    check("mid_reset_outs", {busy, test_en, done, sc_head}, 0);
    resetb = 1'b1;
    hc = 0;
    repeat (20) begin
      @(negedge op_clk);
      if (done || busy) hc++;
    end
    check("mid_reset_quiet", hc, 0);
    good_chain("after_rst", 8, 8);

    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, MaxLen);
      e = ($urandom_range(0, 1) == 1) ? n : $urandom_range(1, MaxLen);
      good_chain($sformatf("rand%0d", k), n, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
